sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM read master, the initiator side of the system-ID slave's control interface.
- On a start pulse, reads the ID word and then the timestamp word from the sysid slave and compares each against expected values.
- Reports pass/fail plus the captured words to the host/boot controller.
- Sits between boot sequencing logic and the sysid slave on the system interconnect.

Parameters:
- ADDR_W, 1, width of avm_address.
- ID_ADDR, 0, word address of the ID register.
- TS_ADDR, 1, word address of the timestamp register.
- EXPECTED_ID, 0, 32-bit value required at ID_ADDR.
- EXPECTED_TS, 1529059747, 32-bit value required at TS_ADDR.
- USE_RDV, 0. If 0, data is captured in the cycle waitrequest is low. If 1, data is captured on avm_readdatavalid.
- TIMEOUT_CYCLES, 255, per-attempt cycle limit (1..65535).
- MAX_RETRIES, 2, extra attempts per word after the first timeout.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check
- avm_address  out  ADDR_W  read address
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid (used only when USE_RDV=1)
- busy  out  1  check in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  both words matched, no timeout
- err_id  out  1  ID mismatch
- err_ts  out  1  timestamp mismatch
- err_timeout  out  1  retries exhausted on either word
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Interface: one clock `clock`; reset `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0 (avm_address 0, avm_read 0, status 0, captured values 0). FSM enters IDLE; counters cleared.
- Reset asserted mid-transaction: avm_read drops immediately (asynchronous). No done pulse is issued.

FSM states:
- IDLE:
  - busy=0.
  - start=1 → clear pass/err_*/id_value/ts_value, clear retry count, go to ID_REQ.
- ID_REQ / TS_REQ:
  - avm_read=1; avm_address = ID_ADDR or TS_ADDR.
  - Held stable while avm_waitrequest=1.
  - Accept (read=1 && waitrequest=0):
    - USE_RDV=0 → capture readdata, go to the next word (TS_REQ) or CHECK.
    - USE_RDV=1 → go to ID_WAIT / TS_WAIT.
- ID_WAIT / TS_WAIT:
  - avm_read=0.
  - Capture readdata when avm_readdatavalid=1, then go to TS_REQ or CHECK.
- CHECK:
  - err_id = (id_value != EXPECTED_ID).
  - err_ts = (ts_value != EXPECTED_TS).
  - pass = !err_id && !err_ts && !err_timeout.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, go to IDLE. Status and captured words hold until the next accepted start.

Timeout and retry:
- Attempt counter is 16 bits. It clears on entry to each REQ state and increments every cycle in REQ/WAIT.
- At count == TIMEOUT_CYCLES-1 without capture: avm_read is low for one cycle, then the same REQ is re-entered and the retry count increments.
- Retry count is per word and clears when a word completes.
- Timeout with retry count == MAX_RETRIES: set err_timeout. The captured word for that word stays 0. If the ID read timed out, the TS read is skipped. Go to CHECK.
- Stale readdatavalid arriving in a REQ state is ignored.

Other rules:
- busy=1 in every state except IDLE, including DONE.
- start while busy is ignored (no queuing).
- start in the same cycle as done: ignored. A new start is accepted from IDLE one cycle later.
- Latency, zero-wait slave, USE_RDV=0:
  - start sampled at edge k.
  - avm_read high in cycles k+1 (ID) and k+2 (TS).
  - CHECK in cycle k+3.
  - done high in cycle k+4.
- Each wait-state cycle or readdatavalid delay adds exactly one cycle.

Test Plan:
- Zero-wait slave returning 0 at address 0 and 1529059747 at address 1, USE_RDV=0, start pulse → avm_read high in cycles k+1 and k+2 with addresses 0 then 1; done in cycle k+4; pass=1; id_value=0; ts_value=1529059747.
- Same slave but the timestamp returns 0 → done, pass=0, err_ts=1, err_id=0, ts_value=0.
- waitrequest held 3 cycles on the ID read → avm_address=0 and avm_read stable through the stall; done at k+7; pass=1.
- USE_RDV=1, readdatavalid 2 cycles after accept on each read → avm_read low during WAIT; correct capture; pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=8, MAX_RETRIES=2 → three 8-cycle attempts each separated by one read-low cycle; err_timeout=1; no TS read; pass=0; done once.
- start re-pulsed while busy, and reset_n dropped mid-TS read → extra start ignored; on reset all outputs 0 asynchronously, no done; a later start runs a clean check.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words on request
// and reports whether they match the expected build values.
module sysid_checker #(
    parameter int unsigned ADDR_W         = 1,
    parameter int unsigned ID_ADDR        = 0,
    parameter int unsigned TS_ADDR        = 1,
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1529059747,
    parameter bit          USE_RDV        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_id,
    output logic              err_ts,
    output logic              err_timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_IDLE, S_ID_REQ, S_ID_WAIT, S_ID_GAP,
        S_TS_REQ, S_TS_WAIT, S_TS_GAP, S_CHECK, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt;
    logic [RW-1:0] retry;
    logic          tmo, last_try;
    logic          cap_id, cap_ts, to_fail;
    logic          req_entry, in_attempt;

    assign tmo      = (cnt == TO_LAST);
    assign last_try = (retry == RETRY_MAX);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = '0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        to_fail     = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_ID_REQ;
            S_ID_REQ: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'(ID_ADDR);
                if (!avm_waitrequest) begin
                    if (USE_RDV) state_nxt = S_ID_WAIT;
                    else begin
                        cap_id    = 1'b1;
                        state_nxt = S_TS_REQ;
                    end
                end else if (tmo) begin
                    to_fail   = last_try;
                    state_nxt = last_try ? S_CHECK : S_ID_GAP;
                end
            end
            S_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_id    = 1'b1;
                    state_nxt = S_TS_REQ;
                end else if (tmo) begin
                    to_fail   = last_try;
                    state_nxt = last_try ? S_CHECK : S_ID_GAP;
                end
            end
            S_ID_GAP: state_nxt = S_ID_REQ;
            S_TS_REQ: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'(TS_ADDR);
                if (!avm_waitrequest) begin
                    if (USE_RDV) state_nxt = S_TS_WAIT;
                    else begin
                        cap_ts    = 1'b1;
                        state_nxt = S_CHECK;
                    end
                end else if (tmo) begin
                    to_fail   = last_try;
                    state_nxt = last_try ? S_CHECK : S_TS_GAP;
                end
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_ts    = 1'b1;
                    state_nxt = S_CHECK;
                end else if (tmo) begin
                    to_fail   = last_try;
                    state_nxt = last_try ? S_CHECK : S_TS_GAP;
                end
            end
            S_TS_GAP: state_nxt = S_TS_REQ;
            S_CHECK:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The attempt counter spans REQ and WAIT so a slow readdatavalid also times out.
    assign req_entry  = (state_nxt == S_ID_REQ && state != S_ID_REQ) ||
                        (state_nxt == S_TS_REQ && state != S_TS_REQ);
    assign in_attempt = (state == S_ID_REQ) || (state == S_ID_WAIT) ||
                        (state == S_TS_REQ) || (state == S_TS_WAIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            retry       <= '0;
            pass        <= 1'b0;
            err_id      <= 1'b0;
            err_ts      <= 1'b0;
            err_timeout <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state <= state_nxt;

            if (req_entry)       cnt <= '0;
            else if (in_attempt) cnt <= cnt + 16'd1;

            if (state == S_IDLE || cap_id || cap_ts)       retry <= '0;
            else if (state == S_ID_GAP || state == S_TS_GAP) retry <= retry + 1'b1;

            if (state == S_IDLE && start) begin
                pass        <= 1'b0;
                err_id      <= 1'b0;
                err_ts      <= 1'b0;
                err_timeout <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end

            if (cap_id)  id_value    <= avm_readdata;
            if (cap_ts)  ts_value    <= avm_readdata;
            if (to_fail) err_timeout <= 1'b1;

            if (state == S_CHECK) begin
                err_id <= (id_value != EXPECTED_ID);
                err_ts <= (ts_value != EXPECTED_TS);
                pass   <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS) && !err_timeout;
            end
        end
    end

endmodule
